// File: rtl/simon_ti_host_seq.sv
// -----------------------------------------------------------------------------
// simon_ti_host_seq
//
// Host-side sequencer for the two-share threshold-implementation bit-serial
// SIMON core. It gathers the shared input block (plaintext and key shares)
// from 32-bit host writes and issues a single-cycle load strobe once the core
// is idle. It then waits for the core's valid flag, captures the result and
// hands it back to the host as a sequence of 32-bit reads, MSB word first.
//
// Optional feature: define SIMON_HOST_TIMEOUT_EN to bound the wait for
// core_dvld to TIMEOUT cycles. On expiry, err is set and the block returns
// to FILL. Without the macro the wait is unbounded and err is tied to 0.
//
// Ports
//   CLK, RST   clock (rising edge), asynchronous active-high reset
//   wr_en      host write strobe; taken only while wr_rdy=1
//   wr_data    host write word
//   wr_rdy     high while the input block is being filled
//   rd_en      host read pop; taken only while rd_vld=1
//   rd_data    result word currently presented to the host
//   rd_vld     high while result words are available
//   err        sticky timeout flag; cleared by the next accepted write
//   core_din   core Din bus (held stable from ARM until the next write)
//   core_drdy  core Drdy single-cycle load strobe
//   core_en    core EN; 0 in reset, 1 from the first edge after reset
//   core_dout  core Dout bus
//   core_dvld  core Dvld flag
//   core_bsy   core BSY flag; no load is strobed while it is high
// -----------------------------------------------------------------------------
module simon_ti_host_seq #(
  parameter int DIN_W   = 768,
  parameter int DOUT_W  = 128,
  parameter int WORD_W  = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_rdy,
  input  logic              rd_en,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_vld,
  output logic              err,
  output logic [DIN_W-1:0]  core_din,
  output logic              core_drdy,
  output logic              core_en,
  input  logic [DOUT_W-1:0] core_dout,
  input  logic              core_dvld,
  input  logic              core_bsy
);

  localparam int NW_IN  = DIN_W / WORD_W;
  localparam int NW_OUT = DOUT_W / WORD_W;
  localparam int WC_W   = (NW_IN  > 1) ? $clog2(NW_IN)  : 1;
  localparam int RC_W   = (NW_OUT > 1) ? $clog2(NW_OUT) : 1;

  // Elaboration-time guard on the geometry; the timeout counter is 16 bits.
  if ((DIN_W % WORD_W) != 0 || (DOUT_W % WORD_W) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
    $error("simon_ti_host_seq: illegal parameter combination");
  end

  typedef enum logic [2:0] {FILL, ARM, PULSE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic [WC_W-1:0]   wcnt;
  logic [RC_W-1:0]   rcnt;
  logic [DOUT_W-1:0] result;
  logic              wr_acc, rd_acc, last_w, last_r, tmo;

  // Transfers are only honoured in the state that advertises them.
  assign wr_acc = wr_en && (state == FILL);
  assign rd_acc = rd_en && (state == DONE);
  assign last_w = (wcnt == WC_W'(NW_IN - 1));
  assign last_r = (rcnt == RC_W'(NW_OUT - 1));

  // NOTE: every always_comb output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (wr_acc && last_w) state_nxt = ARM;
      ARM:     if (!core_bsy)        state_nxt = PULSE;
      PULSE:                         state_nxt = WAIT;
      WAIT: begin
        if (core_dvld)               state_nxt = DONE;
        else if (tmo)                state_nxt = FILL;
      end
      DONE:    if (rd_acc && last_r) state_nxt = FILL;
      default:                       state_nxt = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= FILL;
    else     state <= state_nxt;
  end

  // NOTE: core_din and result are ordinary flops with defined reset values
  // seen by the core and host, so they take the async reset like any other
  // control register (unlike a RAM array, which would be left unreset).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt     <= '0;
      rcnt     <= '0;
      core_din <= '0;
      result   <= '0;
      core_en  <= 1'b0;
    end else begin
      core_en <= 1'b1;
      if (wr_acc) begin
        core_din[DIN_W-1-int'(wcnt)*WORD_W -: WORD_W] <= wr_data;
        wcnt <= last_w ? '0 : wcnt + 1'b1;
      end
      if (state == WAIT && core_dvld) begin
        result <= core_dout;
        rcnt   <= '0;
      end else if (rd_acc) begin
        rcnt <= last_r ? '0 : rcnt + 1'b1;
      end
    end
  end

`ifdef SIMON_HOST_TIMEOUT_EN
  logic [15:0] tcnt;
  logic        err_q;

  // tcnt counts completed WAIT cycles without core_dvld; it idles at 0
  // outside WAIT so every wait starts from a fresh budget.
  assign tmo = (tcnt == 16'(TIMEOUT - 1));
  assign err = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == WAIT && !core_dvld) tcnt <= tcnt + 16'd1;
      else                             tcnt <= '0;
      if (state == WAIT && !core_dvld && tmo) err_q <= 1'b1;
      else if (wr_acc)                        err_q <= 1'b0;
    end
  end
`else
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  assign wr_rdy    = (state == FILL);
  assign rd_vld    = (state == DONE);
  assign core_drdy = (state == PULSE);
  assign rd_data   = result[DOUT_W-1-int'(rcnt)*WORD_W -: WORD_W];

endmodule
